// File: rtl/reg_mux_pkg.sv
// Shared definitions for the registered round-robin / fixed-select mux.
package reg_mux_pkg;

    // Arbitration mode as seen on the 1-bit mode port.
    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } mode_e;

    // Increment a channel index, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int v, input int n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping.
// Purely combinational; ptr ownership stays with the parent.
module rr_arbiter #(
    parameter  int p_n = 4,
    localparam int IW  = $clog2(p_n)
) (
    input  logic [p_n-1:0] req,
    input  logic [IW-1:0]  ptr,
    input  logic           en,
    output logic [p_n-1:0] grant,
    output logic [IW-1:0]  idx
);

    logic found;
    int   pos;

    // Scan upward from ptr; the first asserted request wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < p_n; k++) begin
            pos = (int'(ptr) + k) % p_n;
            if (en && !found && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = IW'(pos);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_mux_rr.sv
// Registered N:1 mux with round-robin or fixed-select arbitration and a
// single valid/ready output stage (1-cycle latency, 1 item/cycle).
module reg_mux_rr
    import reg_mux_pkg::*;
#(
    parameter  int p_nbits   = 8,
    parameter  int p_ninputs = 4,
    localparam int SW        = $clog2(p_ninputs)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [p_ninputs-1:0]         in_val,
    input  logic [p_ninputs*p_nbits-1:0] in_data,
    output logic [p_ninputs-1:0]         in_rdy,
    input  logic                         mode,
    input  logic [SW-1:0]                sel,
    output logic                         out_val,
    output logic [p_nbits-1:0]           out_data,
    output logic [SW-1:0]                out_src,
    input  logic                         out_rdy
);

    mode_e                cur_mode;
    logic [SW-1:0]        ptr;
    logic [p_ninputs-1:0] rr_grant;
    logic [SW-1:0]        rr_idx;
    logic [p_ninputs-1:0] fx_grant;
    logic [p_ninputs-1:0] grant;
    logic [SW-1:0]        win;
    logic [p_nbits-1:0]   win_data;
    logic                 load_en;
    logic                 in_xfer;

    assign cur_mode = mode_e'(mode);

    rr_arbiter #(.p_n(p_ninputs)) u_arb (
        .req   (in_val),
        .ptr   (ptr),
        .en    (cur_mode == MODE_RR),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // Fixed mode: only channel sel, and only when it is in range and valid.
    always_comb begin
        fx_grant = '0;
        if (cur_mode == MODE_FIXED && int'(sel) < p_ninputs && in_val[sel])
            fx_grant[sel] = 1'b1;
    end

    // Stage may load when empty or being drained this cycle; never in reset.
    always_comb begin
        grant    = rr_grant | fx_grant;
        win      = (cur_mode == MODE_RR) ? rr_idx : sel;
        load_en  = !out_val || out_rdy;
        in_rdy   = (load_en && !reset) ? grant : '0;
        in_xfer  = |in_rdy;
        win_data = in_data[int'(win)*p_nbits +: p_nbits];
    end

    // Output register and pointer; pointer only advances on RR transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_val  <= 1'b0;
            out_data <= '0;
            out_src  <= '0;
            ptr      <= '0;
        end else if (in_xfer) begin
            out_val  <= 1'b1;
            out_data <= win_data;
            out_src  <= win;
            if (cur_mode == MODE_RR)
                ptr <= SW'(wrap_inc(int'(win), p_ninputs));
        end else if (out_val && out_rdy) begin
            out_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_mux_rr.sv
// Directed-vector bench for reg_mux_rr (4 channels x 8 bits).
module tb_reg_mux_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_val;
    logic [31:0] in_data;
    logic [3:0]  in_rdy;
    logic        mode;
    logic [1:0]  sel;
    logic        out_val;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_rdy;

    int vecs = 0;
    int errs = 0;

    reg_mux_rr #(.p_nbits(8), .p_ninputs(4)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_data(in_data),
        .in_rdy(in_rdy), .mode(mode), .sel(sel), .out_val(out_val),
        .out_data(out_data), .out_src(out_src), .out_rdy(out_rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_val = '0; mode = 1'b0; sel = '0; out_rdy = 1'b0; in_data = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = base + 8'(i);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_val = 4'hF; mode = 1'b0; sel = '0; out_rdy = 1'b1; in_data = 32'h13121110;
        #1;
        vecs++; if (in_rdy !== 4'b0000) begin errs++; $display("FAIL reset_in_rdy: got %b want 0000", in_rdy); end
        tick();
        vecs++; if (out_val !== 1'b0) begin errs++; $display("FAIL reset_out_val: got %b want 0", out_val); end
        vecs++; if (out_data !== 8'h00) begin errs++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        vecs++; if (out_src !== 2'd0) begin errs++; $display("FAIL reset_out_src: got %0d want 0", out_src); end
        vecs++; if (dut.ptr !== 2'd0) begin errs++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr); end
        reset = 1'b0;
    endtask

    task automatic test_rr_fair();
        logic [1:0] exp_src;
        do_reset();
        set_data(8'h10); out_rdy = 1'b1; in_val = 4'hF;
        #1;
        vecs++; if (in_rdy !== 4'b0001) begin errs++; $display("FAIL fair_first_rdy: got %b want 0001", in_rdy); end
        for (int k = 0; k < 5; k++) begin
            exp_src = 2'(k % 4);
            tick();
            vecs++; if (out_val !== 1'b1) begin errs++; $display("FAIL fair_val[%0d]: got %b want 1", k, out_val); end
            vecs++; if (out_src !== exp_src) begin errs++; $display("FAIL fair_src[%0d]: got %0d want %0d", k, out_src, exp_src); end
            vecs++; if (out_data !== 8'h10 + 8'(exp_src)) begin errs++; $display("FAIL fair_data[%0d]: got %h want %h", k, out_data, 8'h10 + 8'(exp_src)); end
            vecs++; if (dut.ptr !== exp_src + 2'd1) begin errs++; $display("FAIL fair_ptr[%0d]: got %0d want %0d", k, dut.ptr, exp_src + 2'd1); end
        end
    endtask

    task automatic test_rr_wrap();
        do_reset();
        set_data(8'h30); out_rdy = 1'b1; in_val = 4'b0100;
        #1;
        vecs++; if (in_rdy !== 4'b0100) begin errs++; $display("FAIL wrap_pre_rdy: got %b want 0100", in_rdy); end
        tick();
        vecs++; if (dut.ptr !== 2'd3) begin errs++; $display("FAIL wrap_ptr3: got %0d want 3", dut.ptr); end
        in_val = 4'b0101;
        #1;
        vecs++; if (in_rdy !== 4'b0001) begin errs++; $display("FAIL wrap_rdy0: got %b want 0001", in_rdy); end
        tick();
        vecs++; if (out_src !== 2'd0 || out_data !== 8'h30) begin errs++; $display("FAIL wrap_out0: got src %0d data %h want src 0 data 30", out_src, out_data); end
        vecs++; if (dut.ptr !== 2'd1) begin errs++; $display("FAIL wrap_ptr1: got %0d want 1", dut.ptr); end
        vecs++; if (in_rdy !== 4'b0100) begin errs++; $display("FAIL wrap_rdy2: got %b want 0100", in_rdy); end
        tick();
        vecs++; if (out_src !== 2'd2 || out_data !== 8'h32) begin errs++; $display("FAIL wrap_out2: got src %0d data %h want src 2 data 32", out_src, out_data); end
        vecs++; if (dut.ptr !== 2'd3) begin errs++; $display("FAIL wrap_ptr3b: got %0d want 3", dut.ptr); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_data(8'h40); in_data[7:0] = 8'h22; out_rdy = 1'b0; in_val = 4'b0001;
        tick();
        vecs++; if (out_val !== 1'b1 || out_data !== 8'h22) begin errs++; $display("FAIL bp_load: got val %b data %h want 1 22", out_val, out_data); end
        in_val = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            vecs++; if (in_rdy !== 4'b0000) begin errs++; $display("FAIL bp_rdy[%0d]: got %b want 0000", k, in_rdy); end
            tick();
            vecs++; if (out_val !== 1'b1 || out_data !== 8'h22 || out_src !== 2'd0) begin errs++; $display("FAIL bp_hold[%0d]: got val %b data %h src %0d want 1 22 0", k, out_val, out_data, out_src); end
            vecs++; if (dut.ptr !== 2'd1) begin errs++; $display("FAIL bp_ptr[%0d]: got %0d want 1", k, dut.ptr); end
        end
        out_rdy = 1'b1;
        #1;
        vecs++; if (in_rdy !== 4'b0010) begin errs++; $display("FAIL bp_release_rdy: got %b want 0010", in_rdy); end
        tick();
        vecs++; if (out_data !== 8'h41 || out_src !== 2'd1) begin errs++; $display("FAIL bp_release_out: got data %h src %0d want 41 1", out_data, out_src); end
    endtask

    task automatic test_fixed();
        do_reset();
        set_data(8'h50); in_data[23:16] = 8'hC3; mode = 1'b1; sel = 2'd2; out_rdy = 1'b1; in_val = 4'hF;
        #1;
        vecs++; if (in_rdy !== 4'b0100) begin errs++; $display("FAIL fix_rdy: got %b want 0100", in_rdy); end
        for (int k = 0; k < 3; k++) begin
            tick();
            vecs++; if (out_val !== 1'b1 || out_data !== 8'hC3 || out_src !== 2'd2) begin errs++; $display("FAIL fix_out[%0d]: got val %b data %h src %0d want 1 c3 2", k, out_val, out_data, out_src); end
            vecs++; if (dut.ptr !== 2'd0) begin errs++; $display("FAIL fix_ptr[%0d]: got %0d want 0", k, dut.ptr); end
        end
        sel = 2'd3;
        #1;
        vecs++; if (in_rdy !== 4'b1000) begin errs++; $display("FAIL fix_sel_change: got %b want 1000", in_rdy); end
        sel = 2'd2; in_val = 4'b1011;
        #1;
        vecs++; if (in_rdy !== 4'b0000) begin errs++; $display("FAIL fix_nogrant: got %b want 0000", in_rdy); end
        tick();
        vecs++; if (out_val !== 1'b0 || out_data !== 8'hC3) begin errs++; $display("FAIL fix_drain: got val %b data %h want 0 c3", out_val, out_data); end
    endtask

    task automatic test_drain();
        do_reset();
        in_data[7:0] = 8'h77; out_rdy = 1'b1; in_val = 4'b0001;
        tick();
        in_val = 4'b0000;
        vecs++; if (out_val !== 1'b1 || out_data !== 8'h77) begin errs++; $display("FAIL drain_load: got val %b data %h want 1 77", out_val, out_data); end
        #1;
        vecs++; if (in_rdy !== 4'b0000) begin errs++; $display("FAIL drain_rdy: got %b want 0000", in_rdy); end
        tick();
        vecs++; if (out_val !== 1'b0 || out_data !== 8'h77) begin errs++; $display("FAIL drain_clear: got val %b data %h want 0 77", out_val, out_data); end
        vecs++; if (dut.ptr !== 2'd1) begin errs++; $display("FAIL drain_ptr: got %0d want 1", dut.ptr); end
        tick();
        vecs++; if (out_val !== 1'b0) begin errs++; $display("FAIL drain_stay: got %b want 0", out_val); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_data(8'h60); in_data[15:8] = 8'h5A; mode = 1'b1; sel = 2'd1; out_rdy = 1'b0; in_val = 4'b0010;
        tick();
        vecs++; if (out_val !== 1'b1 || out_data !== 8'h5A) begin errs++; $display("FAIL mid_load: got val %b data %h want 1 5a", out_val, out_data); end
        in_val = 4'hF; mode = 1'b0; out_rdy = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        vecs++; if (out_val !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin errs++; $display("FAIL mid_async: got val %b data %h src %0d want 0 00 0", out_val, out_data, out_src); end
        vecs++; if (in_rdy !== 4'b0000) begin errs++; $display("FAIL mid_rdy: got %b want 0000", in_rdy); end
        tick();
        reset = 1'b0;
        #1;
        vecs++; if (in_rdy !== 4'b0001) begin errs++; $display("FAIL mid_post_rdy: got %b want 0001", in_rdy); end
        tick();
        vecs++; if (out_val !== 1'b1 || out_data !== 8'h60 || out_src !== 2'd0) begin errs++; $display("FAIL mid_first: got val %b data %h src %0d want 1 60 0", out_val, out_data, out_src); end
    endtask

    initial begin
        test_reset();
        test_rr_fair();
        test_rr_wrap();
        test_backpressure();
        test_fixed();
        test_drain();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/reg_mux_rr.md
REG_MUX_RR -- requirements
Module: reg_mux_rr

Interface
REQ-001: Parameter p_nbits, 8, data width per channel in bits (SHALL be >= 1).
REQ-002: Parameter p_ninputs, 4, number of input channels (SHALL be 2..16).
REQ-003: Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004: Port reset  input  1  asynchronous, active-high reset.
REQ-005: Port in_val  input  p_ninputs  per-channel valid; bit i belongs to channel i.
REQ-006: Port in_data  input  p_ninputs*p_nbits  packed channel data; channel i occupies bits [i*p_nbits +: p_nbits].
REQ-007: Port in_rdy  output  p_ninputs  per-channel ready; at most one bit SHALL be set.
REQ-008: Port mode  input  1  0 = round-robin arbitration, 1 = fixed select.
REQ-009: Port sel  input  clog2(p_ninputs)  channel index used when mode = 1.
REQ-010: Port out_val  output  1  output register holds valid data.
REQ-011: Port out_data  output  p_nbits  registered data of the granted channel.
REQ-012: Port out_src  output  clog2(p_ninputs)  index of the channel that supplied out_data.
REQ-013: Port out_rdy  input  1  downstream ready.

Function
REQ-014: Transfer on input side SHALL occur when in_val[i] & in_rdy[i]; on output side when out_val & out_rdy.
REQ-015: Stage SHALL be able to load when out_val = 0 or out_rdy = 1 (load_en); in_rdy[i] = grant[i] & load_en.
REQ-016: Round-robin mode: grant SHALL go to the first asserted in_val found scanning upward from pointer ptr, wrapping from p_ninputs-1 to 0.
REQ-017: Fixed mode: grant SHALL go to channel sel only if in_val[sel] = 1; sel >= p_ninputs SHALL grant nothing.
REQ-018: Grant, in_rdy SHALL be combinational from in_val, mode, sel, ptr, out_val, out_rdy; no dependence on in_data.
REQ-019: On input transfer from channel w, next cycle out_val = 1, out_data = channel w data, out_src = w (latency 1 cycle).
REQ-020: Simultaneous output and input transfer SHALL replace the register contents (throughput 1 item/cycle).
REQ-021: Output transfer with no input transfer SHALL clear out_val; out_data/out_src hold their old values.
REQ-022: out_val = 1 and out_rdy = 0 SHALL hold out_val/out_data/out_src stable and drive in_rdy all zero.
REQ-023: ptr SHALL update to (w+1) mod p_ninputs only on an input transfer in round-robin mode; unchanged otherwise, including all fixed-mode transfers.
REQ-024: No in_val asserted SHALL produce no grant and leave ptr unchanged.
REQ-025: mode/sel changes SHALL take effect in the same cycle; a held output item is unaffected.

Reset
REQ-026: reset = 1 SHALL immediately force out_val = 0, out_data = 0, out_src = 0, ptr = 0, independent of clk.
REQ-027: While reset = 1, in_rdy SHALL be all zero; an item held at reset assertion is discarded.
REQ-028: First transfer possible on the first rising clk edge after reset deasserts.

Structure
REQ-029: Mode encodings (MODE_RR = 0, MODE_FIXED = 1) SHALL live in the shared package reg_mux_pkg.
REQ-030: Arbitration SHALL be a sub-module rr_arbiter (inputs req, ptr, en; outputs one-hot grant, encoded index); reg_mux_rr owns ptr, output register and mux.

Verification (p_ninputs = 4, p_nbits = 8)
REQ-031: Reset mid-stream: out_val = 1 holding 0x5A, assert reset between edges -> out_val = 0, out_data = 0 immediately; in_rdy = 0000.
REQ-032: RR fairness: in_val = 1111 constant, out_rdy = 1, data ch i = 0x10+i -> out_src sequence 0,1,2,3,0 on consecutive cycles, out_data 0x10,0x11,0x12,0x13,0x10.
REQ-033: RR skip/wrap: ptr = 3, in_val = 0101 -> grant ch 0, ptr becomes 1; next grant ch 2, ptr becomes 3.
REQ-034: Backpressure: out_val = 1 with 0x22, out_rdy = 0 for 3 cycles, in_val = 1111 -> in_rdy = 0000, out_data stays 0x22, ptr unchanged.
REQ-035: Fixed mode: mode = 1, sel = 2, in_val = 1111, ch2 = 0xC3 -> only in_rdy[2] = 1, out_data = 0xC3, out_src = 2 each cycle, ptr unchanged; in_val[2] = 0 -> no grant.
REQ-036: Drain: single item accepted then in_val = 0000, out_rdy = 1 -> out_val high exactly one cycle then 0.
